// File: rtl/receiver.sv
// USART receive path.
// Oversamples RxD at 16x baud, recovers start/data/parity/stop, checks
// framing and parity, and queues completed frames in a 2-entry buffer
// that the register block reads through UDR.
//
// Ports
//   i_fosk    system clock, all logic on the rising edge
//   i_rst     synchronous active-high reset
//   i_RXEN    receiver enable; low clears FSM, buffer and DOR
//   i_rxclk   one-cycle enable at 16x baud
//   i_RxD     asynchronous serial input, idle high
//   i_ucsz    character size code (000=5 .. 011=8, 111=9, others 8)
//   i_upm     parity mode (0x none, 10 even, 11 odd)
//   i_re_udr  UDR read strobe, pops the buffer head
//   o_udr     head data [7:0]
//   o_rxb8    head data bit 8
//   o_rxc     buffer non-empty
//   o_fe      head framing error
//   o_upe     head parity error
//   o_dor     data overrun, sticky until the next accepted pop
//
// state  | meaning
// IDLE   | waiting for a 1->0 edge on the synchronised line
// START  | validating the start bit at its centre
// DATA   | shifting in data bits, LSB first
// PARITY | capturing and checking the parity bit
// STOP   | checking the first stop bit and pushing the frame
module receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_fosk,
  input  logic       i_rst,
  input  logic       i_RXEN,
  input  logic       i_rxclk,
  input  logic       i_RxD,
  input  logic [2:0] i_ucsz,
  input  logic [1:0] i_upm,
  input  logic       i_re_udr,
  output logic [7:0] o_udr,
  output logic       o_rxb8,
  output logic       o_rxc,
  output logic       o_fe,
  output logic       o_upe,
  output logic       o_dor
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic                   rxd_prev_q;
  logic                   s7_q, s8_q;
  logic                   maj;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] nbits_q, nbits_d;
  logic       par_en_q, par_en_d;
  logic       par_odd_q, par_odd_d;
  logic [8:0] data_q, data_d;
  logic       upe_q, upe_d;
  logic       push, push_fe;

  // Buffer entries are {data[7:0], rxb8, fe, upe}; empty slots hold zero so
  // the head register drives the outputs directly.
  logic [10:0] head_q, tail_q;
  logic [1:0]  count_q;
  logic        dor_q;
  logic        pop, push_ok;
  logic [10:0] new_entry;

  function automatic logic [3:0] frame_bits(input logic [2:0] ucsz);
    case (ucsz)
      3'b000:  return 4'd5;
      3'b001:  return 4'd6;
      3'b010:  return 4'd7;
      3'b111:  return 4'd9;
      default: return 4'd8;
    endcase
  endfunction

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // Synchroniser and edge-detect history keep running while disabled so a
  // re-enabled receiver sees the true line level.
  always_ff @(posedge i_fosk) begin
    if (i_rst) begin
      sync_q     <= '1;
      rxd_prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_RxD};
      if (i_rxclk) rxd_prev_q <= rxd_s;
    end
  end

  // Samples at ticks 7 and 8; tick 9 uses the live value for the vote.
  always_ff @(posedge i_fosk) begin
    if (i_rst) begin
      s7_q <= 1'b0;
      s8_q <= 1'b0;
    end else if (i_rxclk) begin
      if (cnt_q == 4'd7) s7_q <= rxd_s;
      if (cnt_q == 4'd8) s8_q <= rxd_s;
    end
  end

  assign maj = (s7_q & s8_q) | (s7_q & rxd_s) | (s8_q & rxd_s);

  always_ff @(posedge i_fosk) begin
    if (i_rst || !i_RXEN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      nbits_q   <= 4'd8;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      data_q    <= '0;
      upe_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      nbits_q   <= nbits_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      data_q    <= data_d;
      upe_q     <= upe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    data_d    = data_q;
    upe_d     = upe_q;
    push      = 1'b0;
    push_fe   = 1'b0;

    if (i_rxclk) begin
      cnt_d = cnt_q + 4'd1;
      case (state_q)
        IDLE: begin
          if (rxd_prev_q && !rxd_s) begin
            state_d   = START;
            cnt_d     = '0;
            bit_cnt_d = '0;
            data_d    = '0;
            upe_d     = 1'b0;
            nbits_d   = frame_bits(i_ucsz);
            par_en_d  = i_upm[1];
            par_odd_d = i_upm[0];
          end
        end
        START: begin
          if (cnt_q == 4'd9) begin
            state_d   = maj ? IDLE : DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          if (cnt_q == 4'd9) begin
            data_d[bit_cnt_q] = maj;
            bit_cnt_d         = bit_cnt_q + 4'd1;
            if (bit_cnt_q == nbits_q - 4'd1)
              state_d = par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (cnt_q == 4'd9) begin
            // Unused upper data bits are zero, so the full-width XOR is safe.
            upe_d   = maj ^ (^data_q) ^ par_odd_q;
            state_d = STOP;
          end
        end
        STOP: begin
          // Leave mid-stop-bit so a back-to-back start edge is not missed.
          if (cnt_q == 4'd9) begin
            push    = 1'b1;
            push_fe = ~maj;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign new_entry = {data_q[7:0], data_q[8], push_fe, upe_q};
  assign pop       = i_re_udr && (count_q != 2'd0);
  assign push_ok   = push && ((count_q != 2'd2) || pop);

  always_ff @(posedge i_fosk) begin
    if (i_rst || !i_RXEN) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dor_q   <= 1'b0;
    end else begin
      if (pop && push) begin
        if (count_q == 2'd1) begin
          head_q <= new_entry;
        end else begin
          head_q <= tail_q;
          tail_q <= new_entry;
        end
      end else if (pop) begin
        head_q  <= tail_q;
        tail_q  <= '0;
        count_q <= count_q - 2'd1;
      end else if (push_ok) begin
        if (count_q == 2'd0) head_q <= new_entry;
        else                 tail_q <= new_entry;
        count_q <= count_q + 2'd1;
      end

      if (push && !push_ok) dor_q <= 1'b1;
      else if (pop)         dor_q <= 1'b0;
    end
  end

  assign o_udr  = head_q[10:3];
  assign o_rxb8 = head_q[2];
  assign o_fe   = head_q[1];
  assign o_upe  = head_q[0];
  assign o_rxc  = (count_q != 2'd0);
  assign o_dor  = dor_q;

endmodule

// File: tb/tb_receiver.sv
// Bench for the USART receiver: directed scenarios plus randomized frames,
// checked against a frame-level model of the receive buffer.
module tb_receiver;

  logic       i_fosk = 1'b0;
  logic       i_rst;
  logic       i_RXEN;
  logic       i_rxclk;
  logic       i_RxD;
  logic [2:0] i_ucsz;
  logic [1:0] i_upm;
  logic       i_re_udr;
  logic [7:0] o_udr;
  logic       o_rxb8, o_rxc, o_fe, o_upe, o_dor;

  int checks = 0;
  int errors = 0;

  logic [10:0] mq[$];
  logic        mdor = 1'b0;

  receiver #(.SYNC_STAGES(2)) dut (
    .i_fosk  (i_fosk),
    .i_rst   (i_rst),
    .i_RXEN  (i_RXEN),
    .i_rxclk (i_rxclk),
    .i_RxD   (i_RxD),
    .i_ucsz  (i_ucsz),
    .i_upm   (i_upm),
    .i_re_udr(i_re_udr),
    .o_udr   (o_udr),
    .o_rxb8  (o_rxb8),
    .o_rxc   (o_rxc),
    .o_fe    (o_fe),
    .o_upe   (o_upe),
    .o_dor   (o_dor)
  );

  always #5 i_fosk = ~i_fosk;

  // 16x baud enable: one cycle in four, changed on the falling edge.
  initial begin
    i_rxclk = 1'b0;
    forever begin
      repeat (3) @(negedge i_fosk);
      i_rxclk = 1'b1;
      @(negedge i_fosk);
      i_rxclk = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] status();
    return {o_rxc, o_dor, o_udr, o_rxb8, o_fe, o_upe};
  endfunction

  function automatic logic [12:0] exp_status();
    if (mq.size() == 0) return {1'b0, mdor, 11'h000};
    return {1'b1, mdor, mq[0]};
  endfunction

  function automatic int nbits_of(input logic [2:0] ucsz);
    case (ucsz)
      3'd0:    return 5;
      3'd1:    return 6;
      3'd2:    return 7;
      3'd7:    return 9;
      default: return 8;
    endcase
  endfunction

  function automatic logic good_parity(input logic [8:0] data, input logic [2:0] ucsz, input logic [1:0] upm);
    logic [8:0] d;
    d = data & 9'((1 << nbits_of(ucsz)) - 1);
    return (^d) ^ upm[0];
  endfunction

  task automatic model_push(input logic [10:0] e);
    if (mq.size() < 2) mq.push_back(e);
    else               mdor = 1'b1;
  endtask

  task automatic model_clear();
    mq.delete();
    mdor = 1'b0;
  endtask

  // Returns #1 after a clock edge at which i_rxclk was high.
  task automatic tick();
    do @(posedge i_fosk); while (i_rxclk !== 1'b1);
    #1;
  endtask

  task automatic send_frame(input logic [8:0] data, input logic [2:0] ucsz,
                            input logic [1:0] upm, input logic pbit, input logic stop);
    int          n;
    logic [8:0]  d;
    logic [10:0] e;
    bit          was_empty;
    n = nbits_of(ucsz);
    d = data & 9'((1 << n) - 1);
    e = {d[7:0], d[8], ~stop, upm[1] ? (pbit ^ (^d) ^ upm[0]) : 1'b0};
    i_ucsz = ucsz;
    i_upm  = upm;
    i_RxD  = 1'b1;
    tick();
    was_empty = (mq.size() == 0);
    i_RxD = 1'b0;
    repeat (16) tick();
    // Configuration is latched at the start edge; scramble it mid-frame.
    i_ucsz = 3'($urandom);
    i_upm  = 2'($urandom);
    for (int i = 0; i < n; i++) begin
      i_RxD = data[i];
      repeat (16) tick();
    end
    if (upm[1]) begin
      i_RxD = pbit;
      repeat (16) tick();
    end
    i_RxD = stop;
    for (int p = 1; p <= 16; p++) begin
      tick();
      if (was_empty && p == 10) check("rxc_early", 13'(o_rxc), 13'd0);
      if (p == 11) begin
        if (was_empty) check("rxc_latency", 13'(o_rxc), 13'd1);
        model_push(e);
      end
    end
    i_RxD = 1'b1;
    check("frame", status(), exp_status());
  endtask

  task automatic read_udr();
    check("pre_read", status(), exp_status());
    i_re_udr = 1'b1;
    @(posedge i_fosk);
    #1;
    i_re_udr = 1'b0;
    if (mq.size() != 0) begin
      void'(mq.pop_front());
      mdor = 1'b0;
    end
    check("post_read", status(), exp_status());
  endtask

  // Frame cut off halfway through data bit 3 by reset or RXEN low.
  task automatic abort_frame(input bit use_rst);
    i_ucsz = 3'b011;
    i_upm  = 2'b00;
    i_RxD  = 1'b1;
    tick();
    i_RxD = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 3; i++) begin
      i_RxD = 1'($urandom);
      repeat (16) tick();
    end
    i_RxD = 1'b0;
    repeat (8) tick();
    i_RxD = 1'b1;
    if (use_rst) begin
      i_rst = 1'b1;
      @(posedge i_fosk);
      #1;
      i_rst = 1'b0;
    end else begin
      i_RXEN = 1'b0;
      repeat (3) tick();
      i_RXEN = 1'b1;
    end
    model_clear();
    repeat (20) tick();
    check(use_rst ? "abort_rst" : "abort_rxen", status(), exp_status());
  endtask

  initial begin
    i_rst    = 1'b1;
    i_RXEN   = 1'b1;
    i_RxD    = 1'b1;
    i_ucsz   = 3'b011;
    i_upm    = 2'b00;
    i_re_udr = 1'b0;
    repeat (3) @(posedge i_fosk);
    #1;
    i_rst = 1'b0;
    check("reset", status(), 13'd0);

    // 8N1 0xA5
    send_frame(9'h0A5, 3'b011, 2'b00, 1'b0, 1'b1);
    read_udr();

    // 9-bit even parity, correct then wrong parity bit
    send_frame(9'h13C, 3'b111, 2'b10, 1'b1, 1'b1);
    read_udr();
    send_frame(9'h13C, 3'b111, 2'b10, 1'b0, 1'b1);
    read_udr();

    // 5O1 with forced framing error, then a clean frame
    send_frame(9'h015, 3'b000, 2'b11, good_parity(9'h015, 3'b000, 2'b11), 1'b0);
    send_frame(9'h00A, 3'b000, 2'b11, good_parity(9'h00A, 3'b000, 2'b11), 1'b1);
    read_udr();
    read_udr();

    // False start: low for 6 ticks only
    i_RxD = 1'b0;
    repeat (6) tick();
    i_RxD = 1'b1;
    repeat (20) tick();
    check("false_start", status(), exp_status());
    send_frame(9'h055, 3'b011, 2'b00, 1'b0, 1'b1);
    read_udr();

    // Overrun
    send_frame(9'h001, 3'b011, 2'b00, 1'b0, 1'b1);
    send_frame(9'h002, 3'b011, 2'b00, 1'b0, 1'b1);
    send_frame(9'h003, 3'b011, 2'b00, 1'b0, 1'b1);
    read_udr();
    read_udr();
    read_udr();

    // Aborts with a frame already buffered
    send_frame(9'h077, 3'b011, 2'b00, 1'b0, 1'b1);
    abort_frame(1'b0);
    send_frame(9'h0C3, 3'b011, 2'b00, 1'b0, 1'b1);
    abort_frame(1'b1);
    send_frame(9'h0C3, 3'b011, 2'b00, 1'b0, 1'b1);
    read_udr();

    // Line held low well past one frame: one FE frame of zeros, nothing more
    i_ucsz = 3'b011;
    i_upm  = 2'b00;
    i_RxD  = 1'b1;
    tick();
    i_RxD = 1'b0;
    repeat (200) tick();
    model_push({8'h00, 1'b0, 1'b1, 1'b0});
    i_RxD = 1'b1;
    repeat (4) tick();
    check("line_low", status(), exp_status());
    read_udr();

    // Randomized frames and reads
    for (int k = 0; k < 30; k++) begin
      logic [8:0] d;
      logic [2:0] uc;
      logic [1:0] up;
      logic       pb, st;
      int         nrd;
      d   = 9'($urandom);
      uc  = 3'($urandom);
      up  = 2'($urandom);
      pb  = good_parity(d, uc, up) ^ ($urandom_range(0, 3) == 0);
      st  = ($urandom_range(0, 5) != 0);
      send_frame(d, uc, up, pb, st);
      nrd = $urandom_range(0, 2);
      for (int r = 0; r < nrd; r++) read_udr();
    end
    while (mq.size() != 0) read_udr();
    read_udr();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
- Asynchronous USART receive path: the companion to the existing transmitter on the same UDR/UCSZ/UPM register set.
- Oversamples RxD at 16x baud, recovers start, data, parity and stop, and checks framing and parity.
- Stores completed frames in a 2-entry receive buffer that the register block reads through UDR.
- Sits beside the transmitter under the USART top. Its sample-rate enable comes from the shared baud generator.

Parameters:
SYNC_STAGES, 2, number of flip-flops synchronising i_RxD to i_fosk (minimum 2)

Ports:
i_fosk  input  1  system clock; all logic on rising edge
i_rst  input  1  synchronous, active-high reset
i_RXEN  input  1  receiver enable (RXEN)
i_rxclk  input  1  one-cycle enable at 16x baud rate
i_RxD  input  1  serial input, asynchronous, idle high
i_ucsz  input  3  data size UCSZ[2:0]: 000=5, 001=6, 010=7, 011=8, 111=9 bits; other codes are treated as 8
i_upm  input  2  parity: 0x=none, 10=even, 11=odd
i_re_udr  input  1  one-cycle UDR read strobe; pops the buffer head
o_udr  output  8  head entry data bits [7:0]
o_rxb8  output  1  head entry bit 8 (RXB8); 0 for frames shorter than 9 bits
o_rxc  output  1  RXC: buffer non-empty
o_fe  output  1  FE of head entry
o_upe  output  1  UPE of head entry
o_dor  output  1  DOR: data overrun, sticky

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - FSM goes to IDLE; sample and bit counters are cleared; buffer is emptied.
  - All outputs are 0. The synchroniser flops load 1.
- i_RXEN=0 has the same effect as reset on the FSM, the buffer and o_dor. The synchroniser keeps running.
- Sampling: a sample counter (4 bits) advances only on i_rxclk. Each bit is 16 ticks. The bit value is the majority of the synchronised RxD at ticks 7, 8 and 9.
- FSM states:
  - IDLE: a 1->0 transition of synchronised RxD (sampled on i_rxclk) clears the sample counter and moves to START.
  - START: at tick 9, majority 0 -> DATA with bit counter = 0. Majority 1 (false start) -> IDLE.
  - DATA: at each tick 9, shift the majority value in LSB-first. After N bits (N from i_ucsz), go to PARITY if i_upm[1]=1, else STOP.
  - PARITY: at tick 9, capture the parity bit.
    - Computed value = XOR of the data bits, then XOR with i_upm[0].
    - upe = captured bit != computed value.
  - STOP: at tick 9, fe = ~majority. Only the first stop bit is checked.
    - Push the frame, then go to IDLE immediately (mid-stop-bit), so a back-to-back start edge is detected.
- Data alignment: bits above N are 0. The 9th bit goes to rxb8.
- i_ucsz and i_upm are sampled at the start edge and held for the frame.
- Buffer: 2 entries of {data[7:0], rxb8, fe, upe}.
  - Push happens the cycle the STOP decision is made; o_rxc rises the next cycle.
  - i_re_udr on a non-empty buffer pops the head; outputs show the new head (or 0s if empty) the next cycle.
  - i_re_udr on an empty buffer is ignored.
  - Push and pop in the same cycle: both take effect, and a full buffer does not overflow.
- Overrun: a push while the buffer is full (and no pop that cycle) discards the new frame and sets o_dor. o_dor clears on the next accepted pop.
- Reset mid-frame: the partial frame is lost and no flag is set.
- Line held low for a whole frame: FE=1 with data 0; the receiver then waits in IDLE for a new 1->0 edge.

Test Plan:
- 8N1 (ucsz=011, upm=00), send 0xA5 -> o_rxc=1 one cycle after stop tick 9; o_udr=0xA5, fe=0, upe=0. One i_re_udr -> o_rxc=0, o_udr=0x00.
- 9-bit even parity (ucsz=111, upm=10), send 0x13C with parity bit 1 -> o_udr=0x3C, o_rxb8=1, upe=0. Repeat with parity bit 0 -> upe=1.
- 5O1 (ucsz=000, upm=11), send 0x15 with stop bit forced 0 -> o_udr=0x15, fe=1. The next valid frame 0x0A is received with fe=0.
- False start: RxD low for 6 rxclk ticks, then high -> no push, FSM back in IDLE. A following real frame 0x55 is received correctly.
- Overrun: send 0x01, 0x02, 0x03 back-to-back with no reads -> o_dor=1 after the third frame. Reads return 0x01 then 0x02; o_dor clears on the first read.
- Abort: drop i_RXEN in the middle of data bit 3, and separately assert i_rst mid-frame -> buffer empty, all outputs 0. The next full frame 0xC3 is received correctly.
